// File: rtl/mem_block_mover_if.sv
// mem_block_mover_if
//   Bundles the command port (control unit side) and the data_memory port
//   of mem_block_mover.
//
//   Command handshake: Start is a one-cycle strobe that is taken only while
//   Busy is low. The operands (Fill, SrcAddr, DstAddr, Len, FillValue) are
//   captured on that same edge. Busy then stays high until the command
//   finishes or is aborted. Done pulses for one cycle on normal completion
//   only. Abort is honoured only while a transfer is in flight.
//
//   Memory port: a write happens on the rising clock edge when
//   MemWriteEnable is high. ReadData is a combinational function of Address.
//
//   Modports:
//     master - the engine (drives Address/WriteData/MemWriteEnable and status)
//     slave  - control unit plus data_memory (drives commands and ReadData)
interface mem_block_mover_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  // command side
  logic                  Start;
  logic                  Fill;
  logic [ADDR_WIDTH-1:0] SrcAddr;
  logic [ADDR_WIDTH-1:0] DstAddr;
  logic [ADDR_WIDTH-1:0] Len;
  logic [DATA_WIDTH-1:0] FillValue;
  logic                  Abort;
  logic                  Busy;
  logic                  Done;
  logic [ADDR_WIDTH-1:0] Count;
  // data_memory side
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWriteEnable;
  logic [DATA_WIDTH-1:0] ReadData;

  modport master (
    input  Start, Fill, SrcAddr, DstAddr, Len, FillValue, Abort, ReadData,
    output Address, WriteData, MemWriteEnable, Busy, Done, Count
  );

  modport slave (
    output Start, Fill, SrcAddr, DstAddr, Len, FillValue, Abort, ReadData,
    input  Address, WriteData, MemWriteEnable, Busy, Done, Count
  );
endinterface

// File: rtl/mem_block_mover.sv
// mem_block_mover
//   Block copy / fill engine for the data_memory port. Each command either
//   copies Len bytes from SrcAddr to DstAddr (READ then WRITE per byte) or
//   fills Len bytes at DstAddr with FillValue (one WRITE per byte).
//   Addresses wrap modulo 2^ADDR_WIDTH. Copies run in ascending order, so an
//   overlapping destination above the source propagates bytes forward.
//
//   Ports:
//     CLK, RST  - clock and asynchronous active-high reset
//     bus       - mem_block_mover_if.master (command + data_memory port)
//     DbgState  - current FSM state (IDLE=0, READ=1, WRITE=2, DONE=3)
module mem_block_mover #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  mem_block_mover_if.master bus,
  output logic [1:0]        DbgState
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic                  fillMode;
  logic [ADDR_WIDTH-1:0] srcBase;
  logic [ADDR_WIDTH-1:0] dstBase;
  logic [ADDR_WIDTH-1:0] lenReg;
  logic [DATA_WIDTH-1:0] fillValue;
  logic [DATA_WIDTH-1:0] dataBuf;
  // Bytes written so far. It doubles as the byte index, because both are
  // cleared on Start and advance together on every WRITE edge.
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] countNext;

  assign countNext = count + ADDR_WIDTH'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      fillMode  <= 1'b0;
      srcBase   <= '0;
      dstBase   <= '0;
      lenReg    <= '0;
      fillValue <= '0;
      dataBuf   <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            fillMode  <= bus.Fill;
            srcBase   <= bus.SrcAddr;
            dstBase   <= bus.DstAddr;
            lenReg    <= bus.Len;
            fillValue <= bus.FillValue;
            count     <= '0;
            if (bus.Len == '0) begin
              state <= DONE;
            end else if (bus.Fill) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (bus.Abort) begin
            state <= IDLE;
          end else begin
            dataBuf <= bus.ReadData;
            state   <= WRITE;
          end
        end
        WRITE: begin
          // The byte presented this cycle is written on this edge even when
          // aborting, so it is always counted.
          count <= countNext;
          if (bus.Abort) begin
            state <= IDLE;
          end else if (countNext == lenReg) begin
            state <= DONE;
          end else if (fillMode) begin
            state <= WRITE;
          end else begin
            state <= READ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory port decoded from state and registers only. Because state resets
  // asynchronously, MemWriteEnable drops as soon as RST rises, which
  // suppresses a write that is in progress.
  always_comb begin
    bus.Address        = '0;
    bus.WriteData      = '0;
    bus.MemWriteEnable = 1'b0;
    case (state)
      READ: begin
        bus.Address = srcBase + count;
      end
      WRITE: begin
        bus.Address        = dstBase + count;
        bus.WriteData      = fillMode ? fillValue : dataBuf;
        bus.MemWriteEnable = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.Busy  = (state != IDLE);
  assign bus.Done  = (state == DONE);
  assign bus.Count = count;
  assign DbgState  = state;

endmodule
